par2ser_tx: RTL and testbench
=============================

// Module: par2ser_tx
// PURPOSE
//   Parallel-to-serial transmitter: accepts a REG_WIDTH-bit word on a valid/ready load port and
//   shifts it out one bit per accepted beat on a valid/ready serial port, flagging the final bit.
//   It is the draining end of the team's parallel register path: words held in a register
//   cascade are handed here and streamed onto a 1-bit link. Back-to-back words run with no bubble.
// PARAMETERS
//   REG_WIDTH  16  word width in bits; legal range >= 2
//   LSB_FIRST  1   1: bit 0 is sent first; 0: bit REG_WIDTH-1 is sent first
// PORTS
//   clk         in   1          single clock; all state changes on its rising edge
//   rst         in   1          asynchronous reset, active-low (0 = reset)
//   load_valid  in   1          upstream presents a word
//   load_ready  out  1          block can accept a word this cycle
//   load_data   in   REG_WIDTH  word to serialize; sampled only on load handshake
//   ser_valid   out  1          ser_data is valid
//   ser_ready   in   1          downstream accepts current bit
//   ser_data    out  1          current bit
//   ser_last    out  1          current bit is the final bit of the word
//   busy        out  1          a word is in flight (state SHIFT)
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, shift reg=0, bit count=0; load_ready=1 after release;
//     ser_valid=0, ser_data=0, ser_last=0, busy=0. Reset mid-word discards the word, no partial flush.
//   Handshakes: a transfer occurs on a cycle where valid&&ready is 1 at the rising clk edge.
//     ser_valid must not drop and ser_data/ser_last must stay stable until ser_ready accepts them.
//   FSM:
//     IDLE : load_ready=1, ser_valid=0. On load handshake: shift reg<=load_data,
//            count<=REG_WIDTH-1, -> SHIFT.
//     SHIFT: ser_valid=1; ser_data = shreg[0] (LSB_FIRST=1) or shreg[REG_WIDTH-1] (LSB_FIRST=0);
//            ser_last = (count==0). On serial handshake with count!=0: shift one position
//            toward the output bit, fill vacated bit with 0, count<=count-1.
//            On serial handshake with count==0: if load_valid, load new word, count<=REG_WIDTH-1,
//            stay SHIFT (zero-bubble); else -> IDLE.
//   load_ready = (state==IDLE) | (state==SHIFT & count==0 & ser_ready). This is a combinational
//     ser_ready->load_ready path; it is intentional and documented for timing.
//   Latency: load handshake at edge N -> first bit valid in cycle N+1; one word takes exactly
//     REG_WIDTH serial handshakes; with ser_ready held 1, throughput = 1 bit/cycle sustained.
//   Counter: width $clog2(REG_WIDTH), counts down, never wraps (reload or IDLE at 0).
//   Stall: ser_ready=0 in SHIFT holds shift reg, count and outputs unchanged for any duration.
//   load_valid in SHIFT (count!=0) is ignored; load_data is never sampled without handshake.
//   busy = (state==SHIFT).
// STRUCTURE
//   Shared package: state encoding localparams (ST_IDLE=1'b0, ST_SHIFT=1'b1) and a
//     count-width function clog2 for reuse by the matching deserializer.
//   One sub-module: par2ser_shreg -- REG_WIDTH-bit register with async active-low clear,
//     parallel load, shift enable, direction parameter; top holds FSM, counter and handshake logic.
// TESTING
//   1. REG_WIDTH=16, LSB_FIRST=1, load 16'hA5C3, ser_ready=1 -> bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1
//      on 16 consecutive cycles; ser_last only on 16th; then load_ready=1, busy=0.
//   2. LSB_FIRST=0, load 16'h8001 -> first bit 1, 14 zeros, last bit 1 with ser_last=1.
//   3. Back-to-back: load 16'hFFFF then 16'h0000 held valid -> 16 ones, 16 zeros, no cycle with
//      ser_valid=0 between words; second load accepted in same cycle as first word's last bit.
//   4. Stall: ser_ready=0 for 5 cycles after bit 3 of 16'h1234 -> ser_data/ser_last/count frozen,
//      stream resumes at bit 3, total 16 accepted bits unchanged.
//   5. Reset mid-word: rst=0 asynchronously after bit 7 -> ser_valid=0, busy=0 immediately
//      (no clk edge); after release load 16'h00FF streams cleanly from bit 0.
//   6. load_valid asserted during SHIFT (count!=0) with 16'hDEAD -> load_ready=0, word not taken,
//      current word output unaffected.

Source files
------------

// File: rtl/par2ser_pkg.sv
// Shared definitions for the parallel/serial register path (serializer and deserializer).
package par2ser_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Bits needed to hold values 0..n-1; minimum of 1 so a 1-bit counter is never zero-width.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 1) ? n - 1 : 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/par2ser_shreg.sv
// Word register with parallel load and single-position shift toward the output end.
module par2ser_shreg #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shifted;

  // Vacated bit is zero-filled; shift direction moves the next bit onto the output end.
  generate
    if (LSB_FIRST != 0) begin : g_lsb
      assign shifted = {1'b0, q[WIDTH-1:1]};
    end else begin : g_msb
      assign shifted = {q[WIDTH-2:0], 1'b0};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= shifted;
    end
  end

endmodule

// File: rtl/par2ser_tx.sv
// Parallel-to-serial transmitter: valid/ready word in, valid/ready bit stream out with last flag.
module par2ser_tx
  import par2ser_pkg::*;
#(
  parameter int unsigned REG_WIDTH = 16,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [REG_WIDTH-1:0] load_data,
  output logic                 ser_valid,
  input  logic                 ser_ready,
  output logic                 ser_data,
  output logic                 ser_last,
  output logic                 busy
);

  localparam int unsigned CNT_W = clog2(REG_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REG_WIDTH - 1);

  logic [0:0]           state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 sh_load, sh_shift;
  logic [REG_WIDTH-1:0] shreg_q;
  logic                 in_shift, at_last;

  par2ser_shreg #(
    .WIDTH     (REG_WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shreg (
    .clk       (clk),
    .rst_n     (rst),
    .load      (sh_load),
    .load_data (load_data),
    .shift     (sh_shift),
    .q         (shreg_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state: reload on the final bit's handshake keeps back-to-back words bubble-free.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          sh_load = 1'b1;
          count_d = CNT_MAX;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ser_ready) begin
          if (count_q != '0) begin
            sh_shift = 1'b1;
            count_d  = count_q - CNT_W'(1);
          end else if (load_valid) begin
            sh_load = 1'b1;
            count_d = CNT_MAX;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_shift = (state_q == ST_SHIFT);
  assign at_last  = (count_q == '0);

  // load_ready deliberately depends combinationally on ser_ready to allow zero-bubble reload.
  assign load_ready = !in_shift || (at_last && ser_ready);
  assign ser_valid  = in_shift;
  assign busy       = in_shift;
  assign ser_last   = in_shift && at_last;
  assign ser_data   = in_shift && ((LSB_FIRST != 0) ? shreg_q[0] : shreg_q[REG_WIDTH-1]);

endmodule

// File: tb/tb_par2ser_tx.sv
// Self-checking bench: LSB-first and MSB-first instances driven in lockstep against a word-level model.
module tb_par2ser_tx;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         ser_ready;
  logic         lr_l, sv_l, sd_l, sl_l, bz_l;
  logic         lr_m, sv_m, sd_m, sl_m, bz_m;

  int n_cmp;
  int n_err;

  // Model: word in flight and index of the bit currently presented (0 = first sent).
  logic         m_busy;
  logic [W-1:0] m_word;
  int           m_idx;
  logic [W-1:0] cap_l, cap_m;

  par2ser_tx #(.REG_WIDTH(W), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr_l), .load_data(load_data),
    .ser_valid(sv_l), .ser_ready(ser_ready), .ser_data(sd_l), .ser_last(sl_l), .busy(bz_l)
  );

  par2ser_tx #(.REG_WIDTH(W), .LSB_FIRST(0)) u_msb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr_m), .load_data(load_data),
    .ser_valid(sv_m), .ser_ready(ser_ready), .ser_data(sd_m), .ser_last(sl_m), .busy(bz_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic exp_last, exp_lr;
    exp_last = m_busy && (m_idx == W - 1);
    exp_lr   = !m_busy || (exp_last && ser_ready);
    chk("lsb_valid", 32'(sv_l), 32'(m_busy));
    chk("lsb_busy",  32'(bz_l), 32'(m_busy));
    chk("lsb_last",  32'(sl_l), 32'(exp_last));
    chk("msb_valid", 32'(sv_m), 32'(m_busy));
    chk("msb_busy",  32'(bz_m), 32'(m_busy));
    chk("msb_last",  32'(sl_m), 32'(exp_last));
    if (rst) begin
      chk("lsb_ready", 32'(lr_l), 32'(exp_lr));
      chk("msb_ready", 32'(lr_m), 32'(exp_lr));
    end
    if (m_busy) begin
      chk("lsb_data", 32'(sd_l), 32'(m_word[m_idx]));
      chk("msb_data", 32'(sd_m), 32'(m_word[W - 1 - m_idx]));
    end
  endtask

  // Advance the model by one clock given this cycle's inputs.
  task automatic model_update(input logic lv, input logic [W-1:0] ld, input logic sr);
    if (!rst) begin
      m_busy = 1'b0;
      m_idx  = 0;
    end else if (!m_busy) begin
      if (lv) begin
        m_busy = 1'b1;
        m_word = ld;
        m_idx  = 0;
      end
    end else if (sr) begin
      if (m_idx == W - 1) begin
        if (lv) begin
          m_word = ld;
          m_idx  = 0;
        end else begin
          m_busy = 1'b0;
        end
      end else begin
        m_idx = m_idx + 1;
      end
    end
  endtask

  task automatic step(input logic lv, input logic [W-1:0] ld, input logic sr);
    @(negedge clk);
    load_valid = lv;
    load_data  = ld;
    ser_ready  = sr;
    #1;
    check_outputs();
    if (sv_l && sr) cap_l = {sd_l, cap_l[W-1:1]};
    if (sv_m && sr) cap_m = {cap_m[W-2:0], sd_m};
    model_update(lv, ld, sr);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), 1'b1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_busy = 1'b0;
    m_word = '0;
    m_idx  = 0;
    cap_l = '0;
    cap_m = '0;
    rst = 1'b0;
    load_valid = 1'b0;
    load_data = '0;
    ser_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(sv_l), 32'd0);
    chk("rst_busy",  32'(bz_l), 32'd0);
    chk("rst_last",  32'(sl_l), 32'd0);
    chk("rst_data",  32'(sd_l), 32'd0);
    chk("rst_data_m", 32'(sd_m), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_ready", 32'(lr_l), 32'd1);

    // Word A5C3 at full rate; 8001 checked MSB-first
    step(1'b1, 16'hA5C3, 1'b1);
    idle_steps(W);
    chk("t1_stream", 32'(cap_l), 32'h0000A5C3);
    step(1'b1, 16'h8001, 1'b1);
    idle_steps(W);
    chk("t2_stream", 32'(cap_m), 32'h00008001);
    chk("t2_idle_ready", 32'(lr_m), 32'd1);

    // Back-to-back with the next word held valid
    step(1'b1, 16'hFFFF, 1'b1);
    for (int i = 0; i < W; i++) step(1'b1, 16'h0000, 1'b1);
    chk("t3_first", 32'(cap_l), 32'h0000FFFF);
    idle_steps(W);
    chk("t3_second", 32'(cap_l), 32'h00000000);

    // Stall after bit 3; offered DEAD during shift must be ignored
    step(1'b1, 16'h1234, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 16'hDEAD, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 16'hDEAD, 1'b0);
    for (int i = 0; i < W - 3; i++) step(1'b0, 16'hDEAD, 1'b1);
    chk("t4_stream", 32'(cap_l), 32'h00001234);
    chk("t4_stream_m", 32'(cap_m), 32'h00001234);
    idle_steps(2);

    // Asynchronous reset mid-word
    step(1'b1, 16'hBEEF, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_update(1'b0, '0, 1'b0);
    #1;
    chk("t5_valid", 32'(sv_l), 32'd0);
    chk("t5_busy",  32'(bz_l), 32'd0);
    chk("t5_busy_m", 32'(bz_m), 32'd0);
    step(1'b0, '0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 16'h00FF, 1'b1);
    idle_steps(W);
    chk("t5_stream", 32'(cap_l), 32'h000000FF);
    chk("t5_stream_m", 32'(cap_m), 32'h000000FF);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    idle_steps(W + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
